// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: load/store func3 codes,
// default address width, access-size decode and alignment helpers.
package data_mem_responder_pkg;

  localparam int ADDR_W_DEF = 16;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Illegal load codes (011, 110, 111) fall into the word case.
  function automatic acc_size_e load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: load_size = SZ_BYTE;
      F3_LH, F3_LHU: load_size = SZ_HALF;
      default:       load_size = SZ_WORD;
    endcase
  endfunction

  // Store size comes from the unshifted byte mask the controller produces.
  function automatic acc_size_e store_size(input logic [3:0] w_en);
    if (w_en[3])      store_size = SZ_WORD;
    else if (w_en[1]) store_size = SZ_HALF;
    else              store_size = SZ_BYTE;
  endfunction

  function automatic logic misaligned(input acc_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// dm_byte_ram: four byte-lane synchronous RAM, shared read/write address,
// per-lane write enable, read-first, no reset. Kept standalone so it can be
// replaced by a vendor macro.
//   clk_i    clock
//   re_i     read enable; rdata_o holds when low
//   we_i     per-lane write enable
//   addr_i   word index
//   wdata_i  lane-aligned write data
//   rdata_o  registered read word (pre-write contents on collision)
module dm_byte_ram #(
  parameter int AW = 14
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  localparam int DEPTH = 1 << AW;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Both non-blocking: the read samples the old contents on a same-word write.
    always_ff @(posedge clk_i) begin
      if (re_i)     rd_q         <= mem[addr_i];
      if (we_i[l])  mem[addr_i]  <= wdata_i[8*l +: 8];
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: aligns store mask/data to the byte address, writes a
// word-organised RAM, and returns a one-cycle-latency aligned and extended
// load result. Flags misaligned loads and stores one cycle after the access.
//   clk_i       clock
//   rst_i       asynchronous active-high reset
//   re_i        load request
//   func3_i     access size / sign
//   addr_i      byte address (bits >= ADDR_W ignored)
//   w_en_i      unshifted store byte mask
//   wdata_i     right-justified store data
//   rdata_o     extended load result, holds between loads
//   rvalid_o    one-cycle pulse per load
//   misalign_o  one-cycle pulse after a misaligned access
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        re_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  w_en_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        misalign_o
);

  logic [1:0]        off;
  logic [ADDR_W-3:0] widx;
  logic              ld_mis, st_act, st_mis;
  logic [3:0]        lane_we;
  logic [31:0]       lane_wdata;
  logic [31:0]       ram_rdata;
  logic              unused_addr;

  assign off         = addr_i[1:0];
  assign widx        = addr_i[ADDR_W-1:2];
  assign unused_addr = ^addr_i[31:ADDR_W];

  assign ld_mis     = misaligned(load_size(func3_i), off);
  assign st_act     = |w_en_i;
  assign st_mis     = misaligned(store_size(w_en_i), off);
  assign lane_we    = (st_act && !st_mis && !rst_i) ? 4'(w_en_i << off) : 4'b0000;
  assign lane_wdata = wdata_i << {off, 3'b000};

  dm_byte_ram #(.AW(ADDR_W - 2)) u_ram (
    .clk_i   (clk_i),
    .re_i    (re_i && !rst_i),
    .we_i    (lane_we),
    .addr_i  (widx),
    .wdata_i (lane_wdata),
    .rdata_o (ram_rdata)
  );

  // Response stage. have_q masks the unreset RAM output until the first load.
  logic        rvalid_q, misalign_q, mis_ld_q, have_q;
  logic        misalign_d;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  assign misalign_d = (re_i && ld_mis) || (st_act && st_mis);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      mis_ld_q   <= 1'b0;
      have_q     <= 1'b0;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
    end else begin
      rvalid_q   <= re_i;
      misalign_q <= misalign_d;
      if (re_i) begin
        off_q    <= off;
        f3_q     <= func3_i;
        mis_ld_q <= ld_mis;
        have_q   <= 1'b1;
      end
    end
  end

  // Extract/extend. Inputs only change on a load, so rdata holds otherwise.
  logic [31:0] shifted, rdata_d;

  always_comb begin
    shifted = ram_rdata >> {off_q, 3'b000};
    rdata_d = shifted;
    case (load_size(f3_q))
      SZ_BYTE: rdata_d = f3_q[2] ? {24'b0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_d = f3_q[2] ? {16'b0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata_d = shifted;
    endcase
    if (!have_q || mis_ld_q) rdata_d = 32'h0;
  end

  assign rdata_o    = rdata_d;
  assign rvalid_o   = rvalid_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        re_i = 1'b0;
  logic [2:0]  func3_i = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [3:0]  w_en_i = 4'b0000;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        misalign_o;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_responder #(.ADDR_W(16)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .re_i       (re_i),
    .func3_i    (func3_i),
    .addr_i     (addr_i),
    .w_en_i     (w_en_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .misalign_o (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; presents the access for one rising edge and returns
  // at the following negedge with the response visible.
  task automatic drive(input logic r, input logic [2:0] f3, input logic [31:0] a,
                       input logic [3:0] we, input logic [31:0] d);
    re_i    = r;
    func3_i = f3;
    addr_i  = a;
    w_en_i  = we;
    wdata_i = d;
    @(negedge clk_i);
    re_i   = 1'b0;
    w_en_i = 4'b0000;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3);
    drive(1'b1, f3, a, 4'b0000, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] we, input logic [2:0] f3,
                       input logic [31:0] d);
    drive(1'b0, f3, a, we, d);
  endtask

  task automatic check_ld(input string tag, input logic [31:0] exp_data, input logic exp_mis);
    check({tag, ".rdata"}, rdata_o, exp_data);
    check({tag, ".rvalid"}, {31'b0, rvalid_o}, 32'd1);
    check({tag, ".misalign"}, {31'b0, misalign_o}, {31'b0, exp_mis});
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst.rdata", rdata_o, 32'h0);
    check("rst.rvalid", {31'b0, rvalid_o}, 32'd0);
    check("rst.misalign", {31'b0, misalign_o}, 32'd0);

    store(32'h100, 4'b1111, 3'b010, 32'hDEADBEEF);
    check("sw100.misalign", {31'b0, misalign_o}, 32'd0);
    check("sw100.rvalid", {31'b0, rvalid_o}, 32'd0);
    load(32'h100, 3'b010);
    check_ld("lw100", 32'hDEADBEEF, 1'b0);
    @(negedge clk_i);
    check("idle.rvalid", {31'b0, rvalid_o}, 32'd0);
    check("idle.hold", rdata_o, 32'hDEADBEEF);

    store(32'h101, 4'b0001, 3'b000, 32'h0000007F);
    load(32'h101, 3'b000);
    check_ld("lb101", 32'h0000007F, 1'b0);
    load(32'h103, 3'b100);
    check_ld("lbu103", 32'h000000DE, 1'b0);
    load(32'h103, 3'b000);
    check_ld("lb103", 32'hFFFFFFDE, 1'b0);

    store(32'h102, 4'b0011, 3'b001, 32'h00008001);
    load(32'h102, 3'b001);
    check_ld("lh102", 32'hFFFF8001, 1'b0);
    load(32'h102, 3'b101);
    check_ld("lhu102", 32'h00008001, 1'b0);
    load(32'h100, 3'b010);
    check_ld("lw100b", 32'h80017FEF, 1'b0);
    load(32'h100, 3'b100);
    check_ld("lbu100", 32'h000000EF, 1'b0);
    load(32'h100, 3'b001);
    check_ld("lh100", 32'h00007FEF, 1'b0);

    load(32'h0001_0100, 3'b010);
    check_ld("alias", 32'h80017FEF, 1'b0);
    load(32'h100, 3'b011);
    check_ld("ill011", 32'h80017FEF, 1'b0);
    load(32'h102, 3'b111);
    check_ld("ill111mis", 32'h0, 1'b1);

    store(32'h200, 4'b1111, 3'b010, 32'h12345678);
    store(32'h202, 4'b1111, 3'b010, 32'hCAFEF00D);
    check("swmis.misalign", {31'b0, misalign_o}, 32'd1);
    check("swmis.rvalid", {31'b0, rvalid_o}, 32'd0);
    @(negedge clk_i);
    check("swmis.pulse", {31'b0, misalign_o}, 32'd0);
    load(32'h200, 3'b010);
    check_ld("lw200", 32'h12345678, 1'b0);
    store(32'h203, 4'b0011, 3'b001, 32'h0000FFFF);
    check("shmis.misalign", {31'b0, misalign_o}, 32'd1);
    load(32'h200, 3'b010);
    check_ld("lw200b", 32'h12345678, 1'b0);
    load(32'h101, 3'b001);
    check_ld("lh101mis", 32'h0, 1'b1);

    store(32'h300, 4'b1111, 3'b010, 32'h22222222);
    drive(1'b1, 3'b010, 32'h300, 4'b1111, 32'h11111111);
    check_ld("rdfirst", 32'h22222222, 1'b0);
    load(32'h300, 3'b010);
    check_ld("rdafter", 32'h11111111, 1'b0);

    store(32'h400, 4'b1111, 3'b010, 32'h33333333);
    re_i    = 1'b1;
    func3_i = 3'b010;
    addr_i  = 32'h100;
    @(posedge clk_i);
    #1;
    rst_i   = 1'b1;
    re_i    = 1'b0;
    addr_i  = 32'h400;
    w_en_i  = 4'b1111;
    wdata_i = 32'h55555555;
    @(negedge clk_i);
    check("midrst.rvalid", {31'b0, rvalid_o}, 32'd0);
    check("midrst.rdata", rdata_o, 32'h0);
    check("midrst.misalign", {31'b0, misalign_o}, 32'd0);
    @(negedge clk_i);
    rst_i  = 1'b0;
    w_en_i = 4'b0000;
    check("postrst.rvalid", {31'b0, rvalid_o}, 32'd0);
    check("postrst.rdata", rdata_o, 32'h0);
    load(32'h400, 3'b010);
    check_ld("rststore", 32'h33333333, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
